gpu_triangle_raster: RTL and testbench
======================================

// Module: gpu_triangle_raster
// PURPOSE
//  Parametrised edge-function triangle rasterizer for the GPU pipeline; sits between
//  triangle setup (bbox/vertex producer) and the framebuffer write stage.
//  Scans the bounding box and emits covered pixel coordinates over a valid/ready stream.
//  Adds over the previous generation: operand latching, backpressure, winding/cull modes,
//  degenerate and empty-box rejection, and correct per-row edge-function reload.
// PARAMETERS
//  CW      16  signed vertex/bbox coordinate width (two's complement)
//  XW      10  framebuffer X output width
//  YW      10  framebuffer Y output width
//  CULL_EN 1   1: honour i_cull_cw; 0: never cull, rasterize both windings
//  localparam EW = 2*CW+3: edge/area accumulator width; CNTW = XW+YW: pixel counter width
// PORTS
//  i_clock        in   1     clock, all logic on rising edge
//  i_reset_n      in   1     asynchronous active-low reset
//  i_request      in   1     start pulse; sampled only in IDLE
//  o_busy         out  1     high from the cycle after an accepted request until DONE
//  o_ready        out  1     one-cycle done pulse (rasterized, culled or empty)
//  o_culled       out  1     valid with o_ready: triangle rejected (degenerate/culled/empty)
//  i_cull_cw      in   1     1: reject clockwise (area<0) triangles when CULL_EN=1
//  i_min_x/y      in   CW    bbox min, inclusive, signed
//  i_max_x/y      in   CW    bbox max, inclusive, signed
//  i_v0_x..i_v2_y in   CW    vertices, signed (six ports)
//  o_fb_x         out  XW    pixel X (low XW bits of scan x)
//  o_fb_y         out  YW    pixel Y (low YW bits of scan y)
//  o_fb_valid     out  1     pixel output valid
//  i_fb_ready     in   1     downstream accepts pixel when valid&&ready
//  o_pixel_count  out  CNTW  pixels emitted for current/last triangle; saturates at all-ones
// BEHAVIOUR
//  Reset: state=IDLE; o_busy, o_ready, o_culled, o_fb_valid, o_fb_x, o_fb_y, o_pixel_count = 0.
//  Reset mid-operation aborts immediately; no further pixels, no o_ready pulse.
//  All inputs except i_fb_ready latched on accepted request; later changes ignored.
//  States: IDLE -> SETUP -> INIT -> SCAN -> DONE -> IDLE.
//   IDLE:  on i_request: latch operands, clear o_pixel_count, -> SETUP.
//   SETUP: a01=v0y-v1y, b01=v1x-v0x, a12, b12, a20, b20 likewise (EW bits, sign-extended);
//          area=orient2d(v0,v1,v2). If min_x>max_x or min_y>max_y or area==0 -> DONE culled.
//          If area<0: CULL_EN&&i_cull_cw -> DONE culled; else set neg flag -> INIT.
//   INIT:  w0r=orient(v1,v2,min), w1r=orient(v2,v0,min), w2r=orient(v0,v1,min); if neg,
//          negate all a/b/w; x=min_x, y=min_y, w=wr -> SCAN.
//   SCAN:  one candidate pixel per cycle unless stalled. Covered iff w0>=0 && w1>=0 && w2>=0.
//          Stall = o_fb_valid && !i_fb_ready: hold x, y, w, o_fb_* unchanged.
//          If not stalled: o_fb_valid<=covered, o_fb_x/y<=x/y if covered; count++ if covered.
//          Step: x<max_x -> x++, w+=a. x==max_x -> x=min_x, y++, wr+=b, w=wr+b.
//          x==max_x && y==max_y (not stalled) -> DONE.
//   DONE:  waits until !o_fb_valid || i_fb_ready (last pixel drained), then o_fb_valid=0,
//          o_ready=1 for exactly one cycle, o_busy=0, -> IDLE. o_culled held until next request.
//  Latency: request at cycle 0 -> first candidate in SCAN at cycle 3 -> o_fb_valid at cycle 4.
//  Throughput: 1 candidate/clock with i_fb_ready=1; bbox of W*H costs W*H SCAN cycles.
//  Edge-on-pixel (w==0) counts as covered; no top-left rule in this revision.
//  All edge arithmetic signed EW bits: no overflow for any CW-bit inputs.
//  i_request while busy is ignored (not queued).
// TESTING
//  CCW tri v0=(0,0) v1=(4,0) v2=(0,4), bbox (0,0)-(4,4), ready=1 -> 15 pixels, count=15, culled=0.
//  Same tri wound CW, i_cull_cw=1 -> o_ready pulse, o_culled=1, zero o_fb_valid cycles, count=0.
//  Same CW tri, i_cull_cw=0 -> identical 15-pixel sequence (order and coords) as CCW case.
//  Collinear v=(0,0),(2,2),(4,4) or bbox min_x=5>max_x=3 -> culled=1, o_ready at cycle 3.
//  Random i_fb_ready toggling on 4x4 tri -> same pixel stream, no drops/duplicates, o_fb_* stable
//  while stalled.
//  Assert i_reset_n low mid-SCAN -> all outputs 0 at once, next request rasterizes normally.

Source files
------------

// File: rtl/gpu_triangle_raster.sv
// Edge-function triangle rasterizer: scans the bounding box and streams covered pixel
// coordinates over valid/ready, with winding-based culling and degenerate rejection.
module gpu_triangle_raster #(
    parameter int CW      = 16,
    parameter int XW      = 10,
    parameter int YW      = 10,
    parameter bit CULL_EN = 1'b1
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_request,
    output logic                 o_busy,
    output logic                 o_ready,
    output logic                 o_culled,
    input  logic                 i_cull_cw,
    input  logic signed [CW-1:0] i_min_x,
    input  logic signed [CW-1:0] i_min_y,
    input  logic signed [CW-1:0] i_max_x,
    input  logic signed [CW-1:0] i_max_y,
    input  logic signed [CW-1:0] i_v0_x,
    input  logic signed [CW-1:0] i_v0_y,
    input  logic signed [CW-1:0] i_v1_x,
    input  logic signed [CW-1:0] i_v1_y,
    input  logic signed [CW-1:0] i_v2_x,
    input  logic signed [CW-1:0] i_v2_y,
    output logic [XW-1:0]        o_fb_x,
    output logic [YW-1:0]        o_fb_y,
    output logic                 o_fb_valid,
    input  logic                 i_fb_ready,
    output logic [XW+YW-1:0]     o_pixel_count
);

    localparam int EW   = 2*CW + 3;
    localparam int CNTW = XW + YW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_INIT,
        S_SCAN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic signed [CW-1:0] r_min_x, r_min_y, r_max_x, r_max_y;
    logic signed [CW-1:0] r_v0_x, r_v0_y, r_v1_x, r_v1_y, r_v2_x, r_v2_y;
    logic                 r_cull_cw;
    logic                 r_neg;
    logic signed [EW-1:0] r_a01, r_b01, r_a12, r_b12, r_a20, r_b20;
    logic signed [EW-1:0] r_w0, r_w1, r_w2;
    logic signed [EW-1:0] r_w0r, r_w1r, r_w2r;
    logic signed [CW-1:0] r_x, r_y;

    logic                 r_busy;
    logic                 r_ready;
    logic                 r_culled;
    logic                 r_fb_valid;
    logic [XW-1:0]        r_fb_x;
    logic [YW-1:0]        r_fb_y;
    logic [CNTW-1:0]      r_count;

    function automatic logic signed [EW-1:0] sx(input logic signed [CW-1:0] v);
        return {{(EW-CW){v[CW-1]}}, v};
    endfunction

    // Twice the signed area of (a,b,c); positive for counter-clockwise winding.
    function automatic logic signed [EW-1:0] orient(
        input logic signed [CW-1:0] ax, input logic signed [CW-1:0] ay,
        input logic signed [CW-1:0] bx, input logic signed [CW-1:0] by,
        input logic signed [CW-1:0] cx, input logic signed [CW-1:0] cy
    );
        return (sx(bx) - sx(ax)) * (sx(cy) - sx(ay)) - (sx(by) - sx(ay)) * (sx(cx) - sx(ax));
    endfunction

    logic signed [EW-1:0] w_area, w_w0_init, w_w1_init, w_w2_init;
    logic                 w_reject, w_covered, w_stall, w_row_end, w_last, w_drained;

    assign w_area    = orient(r_v0_x, r_v0_y, r_v1_x, r_v1_y, r_v2_x, r_v2_y);
    assign w_w0_init = orient(r_v1_x, r_v1_y, r_v2_x, r_v2_y, r_min_x, r_min_y);
    assign w_w1_init = orient(r_v2_x, r_v2_y, r_v0_x, r_v0_y, r_min_x, r_min_y);
    assign w_w2_init = orient(r_v0_x, r_v0_y, r_v1_x, r_v1_y, r_min_x, r_min_y);

    assign w_reject  = (r_min_x > r_max_x) || (r_min_y > r_max_y) || (w_area == '0) ||
                       (w_area[EW-1] && CULL_EN && r_cull_cw);
    assign w_covered = !r_w0[EW-1] && !r_w1[EW-1] && !r_w2[EW-1];
    assign w_stall   = r_fb_valid && !i_fb_ready;
    assign w_row_end = (r_x == r_max_x);
    assign w_last    = w_row_end && (r_y == r_max_y);
    assign w_drained = !r_fb_valid || i_fb_ready;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_request) w_next = S_SETUP;
            S_SETUP: w_next = w_reject ? S_DONE : S_INIT;
            S_INIT:  w_next = S_SCAN;
            S_SCAN:  if (!w_stall && w_last) w_next = S_DONE;
            S_DONE:  if (w_drained) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_min_x    <= '0;
            r_min_y    <= '0;
            r_max_x    <= '0;
            r_max_y    <= '0;
            r_v0_x     <= '0;
            r_v0_y     <= '0;
            r_v1_x     <= '0;
            r_v1_y     <= '0;
            r_v2_x     <= '0;
            r_v2_y     <= '0;
            r_cull_cw  <= 1'b0;
            r_neg      <= 1'b0;
            r_a01      <= '0;
            r_b01      <= '0;
            r_a12      <= '0;
            r_b12      <= '0;
            r_a20      <= '0;
            r_b20      <= '0;
            r_w0       <= '0;
            r_w1       <= '0;
            r_w2       <= '0;
            r_w0r      <= '0;
            r_w1r      <= '0;
            r_w2r      <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_busy     <= 1'b0;
            r_ready    <= 1'b0;
            r_culled   <= 1'b0;
            r_fb_valid <= 1'b0;
            r_fb_x     <= '0;
            r_fb_y     <= '0;
            r_count    <= '0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_request) begin
                        r_min_x   <= i_min_x;
                        r_min_y   <= i_min_y;
                        r_max_x   <= i_max_x;
                        r_max_y   <= i_max_y;
                        r_v0_x    <= i_v0_x;
                        r_v0_y    <= i_v0_y;
                        r_v1_x    <= i_v1_x;
                        r_v1_y    <= i_v1_y;
                        r_v2_x    <= i_v2_x;
                        r_v2_y    <= i_v2_y;
                        r_cull_cw <= i_cull_cw;
                        r_count   <= '0;
                        r_culled  <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                S_SETUP: begin
                    r_a01 <= sx(r_v0_y) - sx(r_v1_y);
                    r_b01 <= sx(r_v1_x) - sx(r_v0_x);
                    r_a12 <= sx(r_v1_y) - sx(r_v2_y);
                    r_b12 <= sx(r_v2_x) - sx(r_v1_x);
                    r_a20 <= sx(r_v2_y) - sx(r_v0_y);
                    r_b20 <= sx(r_v0_x) - sx(r_v2_x);
                    r_neg <= w_area[EW-1];
                    if (w_reject) r_culled <= 1'b1;
                end
                // Clockwise triangles are flipped so the inside test is always w >= 0.
                S_INIT: begin
                    r_a01 <= r_neg ? -r_a01 : r_a01;
                    r_b01 <= r_neg ? -r_b01 : r_b01;
                    r_a12 <= r_neg ? -r_a12 : r_a12;
                    r_b12 <= r_neg ? -r_b12 : r_b12;
                    r_a20 <= r_neg ? -r_a20 : r_a20;
                    r_b20 <= r_neg ? -r_b20 : r_b20;
                    r_w0  <= r_neg ? -w_w0_init : w_w0_init;
                    r_w1  <= r_neg ? -w_w1_init : w_w1_init;
                    r_w2  <= r_neg ? -w_w2_init : w_w2_init;
                    r_w0r <= r_neg ? -w_w0_init : w_w0_init;
                    r_w1r <= r_neg ? -w_w1_init : w_w1_init;
                    r_w2r <= r_neg ? -w_w2_init : w_w2_init;
                    r_x   <= r_min_x;
                    r_y   <= r_min_y;
                end
                S_SCAN: begin
                    if (!w_stall) begin
                        r_fb_valid <= w_covered;
                        if (w_covered) begin
                            r_fb_x <= r_x[XW-1:0];
                            r_fb_y <= r_y[YW-1:0];
                            if (r_count != {CNTW{1'b1}}) r_count <= r_count + CNTW'(1);
                        end
                        // Row wrap restarts from the row-start values rather than undoing x steps.
                        if (w_row_end) begin
                            r_x   <= r_min_x;
                            r_y   <= r_y + CW'(1);
                            r_w0r <= r_w0r + r_b12;
                            r_w1r <= r_w1r + r_b20;
                            r_w2r <= r_w2r + r_b01;
                            r_w0  <= r_w0r + r_b12;
                            r_w1  <= r_w1r + r_b20;
                            r_w2  <= r_w2r + r_b01;
                        end else begin
                            r_x  <= r_x + CW'(1);
                            r_w0 <= r_w0 + r_a12;
                            r_w1 <= r_w1 + r_a20;
                            r_w2 <= r_w2 + r_a01;
                        end
                    end
                end
                S_DONE: begin
                    if (w_drained) begin
                        r_fb_valid <= 1'b0;
                        r_ready    <= 1'b1;
                        r_busy     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy        = r_busy;
    assign o_ready       = r_ready;
    assign o_culled      = r_culled;
    assign o_fb_valid    = r_fb_valid;
    assign o_fb_x        = r_fb_x;
    assign o_fb_y        = r_fb_y;
    assign o_pixel_count = r_count;

endmodule

// File: tb/tb_gpu_triangle_raster.sv
// Scoreboard bench for gpu_triangle_raster: expected pixels are queued per triangle and a
// monitor pops them on every handshake, also watching that stalled outputs hold steady.
module tb_gpu_triangle_raster;

    logic               clk;
    logic               rstN;
    logic               iRequest;
    logic               oBusy, oReady, oCulled;
    logic               iCullCw;
    logic signed [15:0] iMinX, iMinY, iMaxX, iMaxY;
    logic signed [15:0] iV0X, iV0Y, iV1X, iV1Y, iV2X, iV2Y;
    logic [9:0]         oFbX, oFbY;
    logic               oFbValid;
    logic               iFbReady;
    logic [19:0]        oPixelCount;

    int          testsRun;
    int          testsFailed;
    string       curTest;
    bit          randomReady;
    logic [19:0] expQ[$];

    gpu_triangle_raster dut (
        .i_clock      (clk),
        .i_reset_n    (rstN),
        .i_request    (iRequest),
        .o_busy       (oBusy),
        .o_ready      (oReady),
        .o_culled     (oCulled),
        .i_cull_cw    (iCullCw),
        .i_min_x      (iMinX),
        .i_min_y      (iMinY),
        .i_max_x      (iMaxX),
        .i_max_y      (iMaxY),
        .i_v0_x       (iV0X),
        .i_v0_y       (iV0Y),
        .i_v1_x       (iV1X),
        .i_v1_y       (iV1Y),
        .i_v2_x       (iV2X),
        .i_v2_y       (iV2Y),
        .o_fb_x       (oFbX),
        .o_fb_y       (oFbY),
        .o_fb_valid   (oFbValid),
        .i_fb_ready   (iFbReady),
        .o_pixel_count(oPixelCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s/%s: got %0h expected %0h", curTest, name, actual, expected);
        end
    endtask

    // Right triangle with legs along +x/+y from (ox,oy), leg length len, clipped to the bbox.
    task automatic pushTri(input int ox, input int oy, input int len,
                           input int bx0, input int by0, input int bx1, input int by1);
        for (int y = by0; y <= by1; y++) begin
            for (int x = bx0; x <= bx1; x++) begin
                if (x >= ox && y >= oy && (x - ox) + (y - oy) <= len)
                    expQ.push_back({10'(x), 10'(y)});
            end
        end
    endtask

    initial begin
        iFbReady = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            iFbReady = randomReady ? ($urandom_range(0, 1) != 0) : 1'b1;
        end
    end

    initial begin : monitor
        bit         prevStall;
        logic [9:0] prevX, prevY;
        logic [19:0] expPix;
        prevStall = 1'b0;
        prevX = '0;
        prevY = '0;
        forever begin
            @(negedge clk);
            if (!rstN) begin
                prevStall = 1'b0;
                continue;
            end
            if (prevStall)
                checkOutput("stall_hold", {oFbValid, oFbX, oFbY}, {1'b1, prevX, prevY});
            if (oFbValid && iFbReady) begin
                if (expQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL %s/unexpected_pixel: got x=%0d y=%0d expected none", curTest, oFbX, oFbY);
                end else begin
                    expPix = expQ.pop_front();
                    checkOutput("pixel", {oFbX, oFbY}, expPix);
                end
            end
            prevStall = oFbValid && !iFbReady;
            prevX = oFbX;
            prevY = oFbY;
        end
    end

    task automatic applyStimulus(input int v0x, input int v0y, input int v1x, input int v1y,
                                 input int v2x, input int v2y, input int minX, input int minY,
                                 input int maxX, input int maxY, input bit cullCw, input bit disturb,
                                 output int cycles, output int firstValid);
        bit done;
        @(negedge clk);
        iV0X = 16'(v0x); iV0Y = 16'(v0y);
        iV1X = 16'(v1x); iV1Y = 16'(v1y);
        iV2X = 16'(v2x); iV2Y = 16'(v2y);
        iMinX = 16'(minX); iMinY = 16'(minY);
        iMaxX = 16'(maxX); iMaxY = 16'(maxY);
        iCullCw = cullCw;
        iRequest = 1'b1;
        @(posedge clk);
        #1;
        iRequest = 1'b0;
        checkOutput("busy_after_accept", oBusy, 1);
        checkOutput("count_cleared", oPixelCount, 0);
        if (disturb) begin
            iV0X = 16'(0); iV0Y = 16'(0); iV1X = 16'(0); iV1Y = 16'(0);
            iMinX = 16'(5); iMaxX = 16'(3); iCullCw = 1'b1;
        end
        cycles = 0;
        firstValid = -1;
        done = 1'b0;
        while (!done && cycles < 3000) begin
            @(posedge clk);
            #1;
            cycles++;
            if (firstValid < 0 && oFbValid) firstValid = cycles;
            if (disturb) iRequest = (cycles == 5);
            if (oReady) done = 1'b1;
        end
        iRequest = 1'b0;
        if (!done) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL %s/ready_timeout: got no o_ready expected pulse within 3000 cycles", curTest);
        end
    endtask

    task automatic checkDone(input bit expCulled, input int expCount, input int expCycles, input int cycles);
        if (expCycles >= 0) checkOutput("ready_latency", cycles, expCycles);
        checkOutput("culled", oCulled, expCulled);
        checkOutput("pixel_count", oPixelCount, expCount);
        checkOutput("busy_clear", oBusy, 0);
        checkOutput("valid_clear", oFbValid, 0);
        checkOutput("queue_drained", expQ.size(), 0);
        @(posedge clk);
        #1;
        checkOutput("ready_pulse_end", oReady, 0);
        checkOutput("culled_held", oCulled, expCulled);
    endtask

    initial begin
        int cycles, firstValid;
        testsRun = 0;
        testsFailed = 0;
        randomReady = 1'b0;
        curTest = "reset";
        rstN = 1'b0;
        iRequest = 1'b0;
        iCullCw = 1'b0;
        {iMinX, iMinY, iMaxX, iMaxY} = '0;
        {iV0X, iV0Y, iV1X, iV1Y, iV2X, iV2Y} = '0;
        #12;
        checkOutput("reset_outputs", {oBusy, oReady, oCulled, oFbValid, oFbX, oFbY, oPixelCount}, 0);
        @(negedge clk);
        rstN = 1'b1;

        curTest = "ccw_full";
        pushTri(0, 0, 4, 0, 0, 4, 4);
        applyStimulus(0, 0, 4, 0, 0, 4, 0, 0, 4, 4, 1'b0, 1'b0, cycles, firstValid);
        checkOutput("first_valid_latency", firstValid, 3);
        checkDone(1'b0, 15, 28, cycles);

        curTest = "cw_culled";
        applyStimulus(0, 0, 0, 4, 4, 0, 0, 0, 4, 4, 1'b1, 1'b0, cycles, firstValid);
        checkDone(1'b1, 0, 2, cycles);

        curTest = "cw_rasterized";
        pushTri(0, 0, 4, 0, 0, 4, 4);
        applyStimulus(0, 0, 0, 4, 4, 0, 0, 0, 4, 4, 1'b0, 1'b0, cycles, firstValid);
        checkDone(1'b0, 15, 28, cycles);

        curTest = "collinear";
        applyStimulus(0, 0, 2, 2, 4, 4, 0, 0, 4, 4, 1'b0, 1'b0, cycles, firstValid);
        checkDone(1'b1, 0, 2, cycles);

        curTest = "empty_bbox";
        applyStimulus(0, 0, 4, 0, 0, 4, 5, 0, 3, 4, 1'b0, 1'b0, cycles, firstValid);
        checkDone(1'b1, 0, 2, cycles);

        curTest = "clipped_bbox";
        pushTri(0, 0, 4, 1, 1, 3, 3);
        applyStimulus(0, 0, 4, 0, 0, 4, 1, 1, 3, 3, 1'b0, 1'b0, cycles, firstValid);
        checkDone(1'b0, 6, 12, cycles);

        curTest = "negative_coords";
        pushTri(-2, -2, 4, -3, -3, 3, 3);
        applyStimulus(-2, -2, 2, -2, -2, 2, -3, -3, 3, 3, 1'b0, 1'b0, cycles, firstValid);
        checkDone(1'b0, 15, 52, cycles);

        curTest = "latched_operands";
        pushTri(0, 0, 4, 0, 0, 4, 4);
        applyStimulus(0, 0, 4, 0, 0, 4, 0, 0, 4, 4, 1'b0, 1'b1, cycles, firstValid);
        checkDone(1'b0, 15, 28, cycles);

        curTest = "random_backpressure";
        randomReady = 1'b1;
        pushTri(0, 0, 4, 0, 0, 4, 4);
        applyStimulus(0, 0, 4, 0, 0, 4, 0, 0, 4, 4, 1'b0, 1'b0, cycles, firstValid);
        randomReady = 1'b0;
        checkDone(1'b0, 15, -1, cycles);

        curTest = "reset_mid_scan";
        pushTri(0, 0, 4, 0, 0, 4, 4);
        @(negedge clk);
        iV0X = 16'(0); iV0Y = 16'(0); iV1X = 16'(4); iV1Y = 16'(0); iV2X = 16'(0); iV2Y = 16'(4);
        iMinX = 16'(0); iMinY = 16'(0); iMaxX = 16'(4); iMaxY = 16'(4);
        iCullCw = 1'b0;
        iRequest = 1'b1;
        @(posedge clk);
        #1;
        iRequest = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rstN = 1'b0;
        #1;
        checkOutput("abort_outputs", {oBusy, oReady, oCulled, oFbValid, oFbX, oFbY, oPixelCount}, 0);
        expQ.delete();
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("idle_after_abort", {oBusy, oReady, oFbValid}, 0);

        curTest = "after_reset";
        pushTri(0, 0, 4, 0, 0, 4, 4);
        applyStimulus(0, 0, 4, 0, 0, 4, 0, 0, 4, 4, 1'b0, 1'b0, cycles, firstValid);
        checkDone(1'b0, 15, 28, cycles);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
